lstm_neuron_mac: RTL and testbench



---
 rtl/lstm_neuron_mac.sv | 108 ++++++++++
 tb/tb_lstm_neuron_mac.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lstm_neuron_mac.sv
// Serial MAC for one LSTM neuron pre-activation: z = bias + sum(x*w), rescaled
// from Q.8 to Q3.4 and saturated, then held under a valid/ready handshake.
module lstm_neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in__valid,
  output logic       in__ready,
  input  logic [7:0] x__value,
  input  logic [7:0] w__value,
  input  logic [7:0] bias__value,
  output logic       z__valid,
  input  logic       z__ready,
  output logic [7:0] z__value,
  output logic       z__ovf
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);

  typedef enum logic {ST_ACC, ST_OUT} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               z_value_q, z_value_d;
  logic                     z_ovf_q, z_ovf_d;

  logic signed [15:0]       x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext, base, sum, scaled;
  logic                     in_hs;

  assign in__ready = (state_q == ST_ACC) && !rst;
  assign z__valid  = (state_q == ST_OUT);
  assign z__value  = z_value_q;
  assign z__ovf    = z_ovf_q;
  assign in_hs     = in__valid && in__ready;

  // Both operands widened to 16 bits so the product is exact Q6.8.
  assign x_ext    = {{8{x__value[7]}}, x__value};
  assign w_ext    = {{8{w__value[7]}}, w__value};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  assign bias_ext = {{(ACC_W-12){bias__value[7]}}, bias__value, 4'b0000};

  // Element 0 restarts the sum from the bias, dropping any stale accumulator.
  assign base   = (cnt_q == '0) ? bias_ext : acc_q;
  assign sum    = base + prod_ext;
  assign scaled = sum >>> 4;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    z_value_d = z_value_q;
    z_ovf_d   = z_ovf_q;
    unique case (state_q)
      ST_ACC: begin
        if (in_hs) begin
          acc_d = sum;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_OUT;
            if (scaled > SAT_HI) begin
              z_value_d = 8'h7F;
              z_ovf_d   = 1'b1;
            end else if (scaled < SAT_LO) begin
              z_value_d = 8'h80;
              z_ovf_d   = 1'b1;
            end else begin
              z_value_d = scaled[7:0];
              z_ovf_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (z__ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q   <= ST_ACC;
      cnt_q     <= '0;
      acc_q     <= '0;
      z_value_q <= 8'h00;
      z_ovf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      z_value_q <= z_value_d;
      z_ovf_q   <= z_ovf_d;
    end
  end

endmodule

// File: tb/tb_lstm_neuron_mac.sv
// Directed bench for lstm_neuron_mac: table of hand-computed vectors plus
// sequences for bubbles, backpressure and reset corner cases.
module tb_lstm_neuron_mac;

  logic       clk = 1'b0;
  logic       rst;
  logic       in__valid;
  logic       in__ready;
  logic [7:0] x__value;
  logic [7:0] w__value;
  logic [7:0] bias__value;
  logic       z__valid;
  logic       z__ready;
  logic [7:0] z__value;
  logic       z__ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  lstm_neuron_mac #(.N_INPUTS(4), .ACC_W(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .in__valid   (in__valid),
    .in__ready   (in__ready),
    .x__value    (x__value),
    .w__value    (w__value),
    .bias__value (bias__value),
    .z__valid    (z__valid),
    .z__ready    (z__ready),
    .z__value    (z__value),
    .z__ovf      (z__ovf)
  );

  typedef struct {
    string           name;
    logic [7:0]      bias;
    logic [3:0][7:0] x;
    logic [3:0][7:0] w;
    logic [7:0]      exp_z;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Presents one element and returns #1 after the edge that consumed it.
  task automatic push(input logic [7:0] b, input logic [7:0] x, input logic [7:0] w);
    int n = 0;
    in__valid   = 1'b1;
    bias__value = b;
    x__value    = x;
    w__value    = w;
    @(negedge clk);
    while (!in__ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in__ready) check("push_timeout", 32'(in__ready), 32'd1);
    @(posedge clk);
    #1 in__valid = 1'b0;
  endtask

  task automatic collect(input string name, input logic [7:0] ez, input logic eo);
    int n = 0;
    @(negedge clk);
    while (!z__valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({name, "_valid"}, 32'(z__valid), 32'd1);
    check({name, "_z"}, 32'(z__value), 32'(ez));
    check({name, "_ovf"}, 32'(z__ovf), 32'(eo));
    z__ready = 1'b1;
    @(posedge clk);
    #1 z__ready = 1'b0;
    @(negedge clk);
    check({name, "_release_valid"}, 32'(z__valid), 32'd0);
    check({name, "_release_ready"}, 32'(in__ready), 32'd1);
  endtask

  // Non-zero bias on elements k>0 confirms bias is only sampled with element 0.
  task automatic send_vec(input vec_t v);
    for (int k = 0; k < 4; k++)
      push((k == 0) ? v.bias : 8'h55, v.x[k], v.w[k]);
  endtask

  initial begin
    vecs[0] = '{"basic",    8'h10, {8'h10, 8'h10, 8'h10, 8'h10}, {8'h10, 8'h10, 8'h10, 8'h10}, 8'h50, 1'b0};
    vecs[1] = '{"sat_pos",  8'h7F, {8'h7F, 8'h7F, 8'h7F, 8'h7F}, {8'h7F, 8'h7F, 8'h7F, 8'h7F}, 8'h7F, 1'b1};
    vecs[2] = '{"sat_neg",  8'h80, {8'h80, 8'h80, 8'h80, 8'h80}, {8'h7F, 8'h7F, 8'h7F, 8'h7F}, 8'h80, 1'b1};
    vecs[3] = '{"floor_p",  8'h00, {8'h01, 8'h01, 8'h01, 8'h01}, {8'h01, 8'h01, 8'h01, 8'h01}, 8'h00, 1'b0};
    vecs[4] = '{"floor_n",  8'h00, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {8'h01, 8'h01, 8'h01, 8'h01}, 8'hFF, 1'b0};
    vecs[5] = '{"mixed",    8'hF0, {8'h08, 8'hE0, 8'h18, 8'h20}, {8'hF0, 8'h08, 8'h20, 8'h10}, 8'h28, 1'b0};
    vecs[6] = '{"frac_p",   8'h03, {8'h05, 8'h05, 8'h05, 8'h05}, {8'h03, 8'h03, 8'h03, 8'h03}, 8'h06, 1'b0};
    vecs[7] = '{"frac_n",   8'h00, {8'hFD, 8'hFD, 8'hFD, 8'hFD}, {8'h05, 8'h05, 8'h05, 8'h05}, 8'hFC, 1'b0};
    vecs[8] = '{"edge_127", 8'h7F, {8'h00, 8'h00, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00, 8'h00}, 8'h7F, 1'b0};
    vecs[9] = '{"edge_128", 8'h7F, {8'h00, 8'h00, 8'h00, 8'h01}, {8'h00, 8'h00, 8'h00, 8'h10}, 8'h7F, 1'b1};

    rst = 1'b1; in__valid = 1'b0; z__ready = 1'b0;
    x__value = '0; w__value = '0; bias__value = '0;
    @(negedge clk);
    check("rst_in_ready", 32'(in__ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready_after", 32'(in__ready), 32'd1);
    check("rst_z_valid", 32'(z__valid), 32'd0);
    check("rst_z_value", 32'(z__value), 32'd0);
    check("rst_z_ovf", 32'(z__ovf), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      send_vec(vecs[i]);
      collect(vecs[i].name, vecs[i].exp_z, vecs[i].exp_ovf);
      @(posedge clk); #1;
    end

    // Bubbles 1,0,0,1,1,0,1 over the mixed vector, with z__valid latency check.
    begin
      logic [6:0] pat;
      int k = 0;
      pat = 7'b1011001;
      for (int c = 0; c < 7; c++) begin
        in__valid   = pat[c];
        bias__value = (k == 0) ? vecs[5].bias : 8'h33;
        x__value    = pat[c] ? vecs[5].x[k] : 8'h7F;
        w__value    = pat[c] ? vecs[5].w[k] : 8'h7F;
        @(negedge clk);
        check("bubble_no_early_valid", 32'(z__valid), 32'd0);
        @(posedge clk); #1;
        if (pat[c]) k++;
      end
      in__valid = 1'b0;
      @(negedge clk);
      check("bubble_latency", 32'(z__valid), 32'd1);
      collect("bubble", vecs[5].exp_z, vecs[5].exp_ovf);
    end
    @(posedge clk); #1;

    // Backpressure: hold the result while the next vector waits at element 0.
    send_vec(vecs[0]);
    in__valid = 1'b1; bias__value = vecs[5].bias;
    x__value = vecs[5].x[0]; w__value = vecs[5].w[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(z__valid), 32'd1);
      check("bp_value", 32'(z__value), 32'h50);
      check("bp_in_ready", 32'(in__ready), 32'd0);
    end
    z__ready = 1'b1;
    @(posedge clk);
    #1 z__ready = 1'b0;
    @(negedge clk);
    check("bp_release_valid", 32'(z__valid), 32'd0);
    check("bp_release_ready", 32'(in__ready), 32'd1);
    @(posedge clk); #1;
    for (int k = 1; k < 4; k++) push(8'h55, vecs[5].x[k], vecs[5].w[k]);
    collect("bp_next", vecs[5].exp_z, vecs[5].exp_ovf);
    @(posedge clk); #1;

    // Reset mid-vector: partial saturating sum must vanish.
    push(8'h7F, 8'h7F, 8'h7F);
    push(8'h55, 8'h7F, 8'h7F);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in__ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(z__valid), 32'd0);
    check("midrst_ready", 32'(in__ready), 32'd1);
    @(posedge clk); #1;
    send_vec(vecs[0]);
    collect("midrst_vec", 8'h50, 1'b0);
    @(posedge clk); #1;

    // Reset while a result is being held.
    send_vec(vecs[1]);
    @(negedge clk);
    check("outrst_pre_valid", 32'(z__valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("outrst_valid", 32'(z__valid), 32'd0);
    check("outrst_value", 32'(z__value), 32'd0);
    check("outrst_ovf", 32'(z__ovf), 32'd0);
    check("outrst_ready", 32'(in__ready), 32'd1);
    @(posedge clk); #1;
    send_vec(vecs[0]);
    collect("outrst_vec", 8'h50, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
